axonerve_wordcount_axi_mem_responder: RTL

//  AXI4 slave (responder) end of the m00_axi subset driven by the wordcount kernel's read/write masters.

---
 rtl/axonerve_wordcount_axi_mem_responder.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/axonerve_wordcount_axi_mem_responder.sv
// rtl/axonerve_wordcount_axi_mem_responder.sv - AXI4 INCR-burst responder over byte-enabled on-chip memory
module axonerve_wordcount_axi_mem_responder #(
  parameter int C_ADDR_WIDTH = 64,
  parameter int C_DATA_WIDTH = 512,
  parameter int C_MEM_DEPTH  = 1024
) (
  input  logic                      ap_clk,
  input  logic                      areset,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [C_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]                s_axi_awlen,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  input  logic [C_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                      s_axi_wlast,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  input  logic [C_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]                s_axi_arlen,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic [C_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic                      s_axi_rlast,
  output logic                      wlast_err
);

  localparam int DW_BYTES = C_DATA_WIDTH / 8;
  localparam int LSB      = $clog2(DW_BYTES);
  localparam int IDX_W    = $clog2(C_MEM_DEPTH);

  // Backing store; contents survive reset.
  logic [C_DATA_WIDTH-1:0] mem [C_MEM_DEPTH];

  // Address bits above the word index and below the beat size are ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr};

  // ---------------------------------------------------------------- write side
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  w_state_t         w_state;
  logic [IDX_W-1:0] w_idx;
  logic [7:0]       w_cnt;
  logic             aw_hs;
  logic             w_hs;
  logic [IDX_W-1:0] aw_idx;

  assign aw_hs  = s_axi_awvalid & s_axi_awready;
  assign w_hs   = s_axi_wvalid & s_axi_wready;
  assign aw_idx = s_axi_awaddr[LSB +: IDX_W];

  // Write burst FSM: one burst in flight, length taken from awlen only.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      w_state       <= W_IDLE;
      s_axi_awready <= 1'b1;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      wlast_err     <= 1'b0;
      w_idx         <= '0;
      w_cnt         <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            w_idx         <= aw_idx;
            w_cnt         <= s_axi_awlen;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b1;
            w_state       <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            w_idx <= w_idx + 1'b1;
            if (w_cnt == 8'd0) begin
              if (!s_axi_wlast) wlast_err <= 1'b1;
              s_axi_wready <= 1'b0;
              s_axi_bvalid <= 1'b1;
              w_state      <= W_RESP;
            end else begin
              if (s_axi_wlast) wlast_err <= 1'b1;
              w_cnt <= w_cnt - 8'd1;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Byte-enabled memory write on each accepted data beat.
  always_ff @(posedge ap_clk) begin
    if (!areset && w_state == W_DATA && w_hs) begin
      for (int b = 0; b < DW_BYTES; b++) begin
        if (s_axi_wstrb[b]) mem[w_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  // ----------------------------------------------------------------- read side
  typedef enum logic {R_IDLE, R_BURST} r_state_t;

  r_state_t          r_state;
  logic [IDX_W-1:0]  f_idx;
  logic [7:0]        f_left;
  logic              m_valid;
  logic              m_last;
  logic [C_DATA_WIDTH-1:0] m_data;
  logic              s_valid;
  logic              s_last;
  logic [C_DATA_WIDTH-1:0] s_data;
  logic              ar_hs;
  logic              r_pop;
  logic [IDX_W-1:0]  ar_idx;
  logic [2:0]        occ;
  logic              burst_issue;
  logic              rd_issue;
  logic [IDX_W-1:0]  rd_addr;

  assign ar_hs  = s_axi_arvalid & s_axi_arready;
  assign r_pop  = s_axi_rvalid & s_axi_rready;
  assign ar_idx = s_axi_araddr[LSB +: IDX_W];

  // Beats held after this edge (output + skid + memory stage, minus the pop);
  // a new fetch is allowed only if its data will always find a free slot.
  assign occ = {2'b00, s_axi_rvalid} + {2'b00, s_valid} + {2'b00, m_valid} - {2'b00, r_pop};
  assign burst_issue = (r_state == R_BURST) && (f_left != 8'd0) && (occ <= 3'd1);
  // The first beat is fetched straight from araddr in the handshake cycle.
  assign rd_issue = ar_hs | burst_issue;
  assign rd_addr  = ar_hs ? ar_idx : f_idx;

  // Synchronous memory read stage; a same-cycle write is not visible here.
  always_ff @(posedge ap_clk) begin
    if (rd_issue) m_data <= mem[rd_addr];
  end

  // Read burst FSM with fetch counter, skid entry and registered R outputs.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b1;
      f_idx         <= '0;
      f_left        <= '0;
      m_valid       <= 1'b0;
      m_last        <= 1'b0;
      s_valid       <= 1'b0;
      s_last        <= 1'b0;
      s_data        <= '0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rdata   <= '0;
    end else begin
      m_valid <= rd_issue;
      if (ar_hs) begin
        f_idx         <= ar_idx + 1'b1;
        f_left        <= s_axi_arlen;
        m_last        <= (s_axi_arlen == 8'd0);
        s_axi_arready <= 1'b0;
        r_state       <= R_BURST;
      end else if (burst_issue) begin
        f_idx  <= f_idx + 1'b1;
        f_left <= f_left - 8'd1;
        m_last <= (f_left == 8'd1);
      end

      if (!s_axi_rvalid || r_pop) begin
        if (s_valid) begin
          s_axi_rdata  <= s_data;
          s_axi_rlast  <= s_last;
          s_axi_rvalid <= 1'b1;
          s_valid      <= m_valid;
          s_data       <= m_data;
          s_last       <= m_last;
        end else begin
          s_axi_rvalid <= m_valid;
          s_axi_rlast  <= m_valid & m_last;
          if (m_valid) s_axi_rdata <= m_data;
        end
      end else if (m_valid) begin
        s_valid <= 1'b1;
        s_data  <= m_data;
        s_last  <= m_last;
      end

      if (r_pop && s_axi_rlast) begin
        r_state       <= R_IDLE;
        s_axi_arready <= 1'b1;
      end
    end
  end

endmodule
